// File: rtl/otter_mmio_pkg.sv
// Register map offsets and control bit positions shared by the MMIO hub.
package otter_mmio_pkg;
  localparam logic [11:0] OUT_OFS      = 12'h000;
  localparam logic [11:0] IN_OFS       = 12'h100;
  localparam logic [11:0] CNT_LO_OFS   = 12'h200;
  localparam logic [11:0] CNT_HI_OFS   = 12'h204;
  localparam logic [11:0] CNT_CTRL_OFS = 12'h208;
  localparam logic [11:0] IRQ_PEND_OFS = 12'h300;
  localparam logic [11:0] IRQ_MASK_OFS = 12'h304;

  localparam int CTRL_RUN = 0;
  localparam int CTRL_CLR = 1;
endpackage

// File: rtl/otter_sync_edge.sv
// Two-flop synchroniser plus one delay stage; flags any bit change of the synced value.
module otter_sync_edge #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         changed
);
  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q       = s2;
  assign changed = (s2 != s3);
endmodule

// File: rtl/otter_mmio_hub.sv
// OTTER IOBUS peripheral hub: output regs, synced inputs, cycle counter with
// atomic 64-bit read, and masked change-detect interrupt.
module otter_mmio_hub
  import otter_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_AD = 32'h1100_0000,
  parameter int NUM_OUT = 2,
  parameter int OUT_W   = 16,
  parameter int NUM_IN  = 1,
  parameter int IN_W    = 16,
  parameter int CNT_W   = 64
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              IOBUS_ADDR,
  input  logic [31:0]              IOBUS_OUT,
  input  logic                     IOBUS_WR,
  input  logic                     IOBUS_RD,
  output logic [31:0]              IOBUS_IN,
  input  logic [NUM_IN*IN_W-1:0]   PINS_IN,
  output logic [NUM_OUT*OUT_W-1:0] PINS_OUT,
  output logic                     INTR
);
  logic [31:0] ofs_full;
  logic [11:0] ofs;
  logic [5:0]  idx;
  logic        hit;

  // Addresses below the base wrap to a huge offset and so miss the window.
  assign ofs_full = IOBUS_ADDR - BASE_AD;
  assign hit      = (ofs_full[31:12] == 20'h0) && (ofs_full[1:0] == 2'b00);
  assign ofs      = ofs_full[11:0];
  assign idx      = ofs[7:2];

  logic wr_out, wr_ctrl, wr_pend, wr_mask, rd_lo;
  assign wr_out  = IOBUS_WR && hit && (ofs[11:8] == OUT_OFS[11:8]);
  assign wr_ctrl = IOBUS_WR && hit && (ofs == CNT_CTRL_OFS);
  assign wr_pend = IOBUS_WR && hit && (ofs == IRQ_PEND_OFS);
  assign wr_mask = IOBUS_WR && hit && (ofs == IRQ_MASK_OFS);
  assign rd_lo   = IOBUS_RD && hit && (ofs == CNT_LO_OFS);

  logic [NUM_OUT-1:0][OUT_W-1:0] out_q;
  logic [NUM_IN-1:0][IN_W-1:0]   in_q;
  logic [NUM_IN-1:0]             chg, pend, mask;
  logic [CNT_W-1:0]              cnt;
  logic [CNT_W-33:0]             hi_q;
  logic                          run;

  for (genvar j = 0; j < NUM_IN; j++) begin : g_in
    otter_sync_edge #(.W(IN_W)) u_sync (
      .clk     (CLK),
      .rst     (RESET),
      .d       (PINS_IN[j*IN_W +: IN_W]),
      .q       (in_q[j]),
      .changed (chg[j])
    );
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_q <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++)
        if (wr_out && idx == 6'(i)) out_q[i] <= IOBUS_OUT[OUT_W-1:0];
    end
  end

  // CLR wins over the increment; RUN comes from the same write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt  <= '0;
      hi_q <= '0;
      run  <= 1'b1;
    end else begin
      if (wr_ctrl) run <= IOBUS_OUT[CTRL_RUN];
      if (wr_ctrl && IOBUS_OUT[CTRL_CLR]) cnt <= '0;
      else if (run)                       cnt <= cnt + CNT_W'(1);
      if (rd_lo) hi_q <= cnt[CNT_W-1:32];
    end
  end

  // A change arriving in the same cycle as a W1C keeps the pending bit set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend <= '0;
      mask <= '0;
      INTR <= 1'b0;
    end else begin
      pend <= (pend & ~(wr_pend ? IOBUS_OUT[NUM_IN-1:0] : '0)) | chg;
      if (wr_mask) mask <= IOBUS_OUT[NUM_IN-1:0];
      INTR <= |(pend & mask);
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    if (hit) begin
      if (ofs[11:8] == OUT_OFS[11:8]) begin
        for (int i = 0; i < NUM_OUT; i++)
          if (idx == 6'(i)) IOBUS_IN = 32'(out_q[i]);
      end else if (ofs[11:8] == IN_OFS[11:8]) begin
        for (int j = 0; j < NUM_IN; j++)
          if (idx == 6'(j)) IOBUS_IN = 32'(in_q[j]);
      end else begin
        case (ofs)
          CNT_LO_OFS:   IOBUS_IN = cnt[31:0];
          CNT_HI_OFS:   IOBUS_IN = 32'(hi_q);
          CNT_CTRL_OFS: IOBUS_IN[CTRL_RUN] = run;
          IRQ_PEND_OFS: IOBUS_IN = 32'(pend);
          IRQ_MASK_OFS: IOBUS_IN = 32'(mask);
          default:      ;
        endcase
      end
    end
  end

  assign PINS_OUT = out_q;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, IOBUS_OUT};
endmodule
